banner_scan_driver: RTL

- Upstream stage of the rotating LED banner: holds the banner digit string, rotates it and time-multiplexes a 4-digit window onto the display.
- Each cycle it presents one 4-bit digit code plus the matching active-low anode pattern.
- The digit code feeds the 7-segment decoder; the anode pattern drives the display directly.

---
 rtl/banner_scan_driver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/banner_scan_driver.sv
// Rotating banner scanner: stores the digit string, rotates it, and multiplexes a 4-digit window.
// Optional pause blink is compiled in when BANNER_BLINK_EN is defined.
module banner_scan_driver #(
    parameter int BANNER_LEN  = 10,
    parameter int STEP_DIV    = 50000000,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       dir,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [3:0] digit,
    output logic [3:0] anode,
    output logic [3:0] pos
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [3:0]        POS_LAST  = 4'(BANNER_LEN - 1);
    localparam logic [4:0]        LEN5      = 5'(BANNER_LEN);

    if (BANNER_LEN < 4 || BANNER_LEN > 16 || STEP_DIV < 1 || REFRESH_DIV < 1 || BLINK_DIV < 1) begin : g_param_check
        $error("banner_scan_driver: parameter out of range");
    end

    logic [3:0]        r_mem [16];
    logic [STEP_W-1:0] r_step_cnt;
    logic [REF_W-1:0]  r_ref_cnt;
    logic [3:0]        r_pos;
    logic [1:0]        r_sel;
    logic [3:0]        r_digit_p1;
    logic [3:0]        r_anode_p1;

    logic              w_step;
    logic              w_ref_tc;
    logic [4:0]        w_idx_raw;
    logic [3:0]        w_idx;
    logic [3:0]        w_anode_pat;
    logic              w_blank;

    assign w_step   = en && (r_step_cnt == STEP_LAST);
    assign w_ref_tc = (r_ref_cnt == REF_LAST);

    // sel=3 is the leftmost digit, so the window offset is 3-sel (= ~sel)
    assign w_idx_raw   = {1'b0, r_pos} + {3'b000, ~r_sel};
    assign w_idx       = (w_idx_raw >= LEN5) ? 4'(w_idx_raw - LEN5) : w_idx_raw[3:0];
    assign w_anode_pat = ~(4'b0001 << r_sel);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 4'(i);
            end
        end else if (wr_en && ({1'b0, wr_addr} < LEN5)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Prescaler freezes while paused so a resumed step is only delayed, not restarted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_step_cnt <= '0;
        end else if (en) begin
            if (r_step_cnt == STEP_LAST) begin
                r_step_cnt <= '0;
            end else begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pos <= '0;
        end else if (w_step) begin
            if (!dir) begin
                r_pos <= (r_pos == POS_LAST) ? 4'd0 : r_pos + 4'd1;
            end else begin
                r_pos <= (r_pos == 4'd0) ? POS_LAST : r_pos - 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ref_cnt <= '0;
            r_sel     <= '0;
        end else if (w_ref_tc) begin
            r_ref_cnt <= '0;
            r_sel     <= r_sel + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

`ifdef BANNER_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_off;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (en) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blank = r_blink_off;
`else
    assign w_blank = 1'b0;
`endif

    // Output stage: registered from the pre-edge pos/sel/mem
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_digit_p1 <= 4'h0;
            r_anode_p1 <= 4'hF;
        end else begin
            r_digit_p1 <= r_mem[w_idx];
            r_anode_p1 <= w_blank ? 4'hF : w_anode_pat;
        end
    end

    assign digit = r_digit_p1;
    assign anode = r_anode_p1;
    assign pos   = r_pos;

endmodule
